// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES registered slices,
// with a stall-all valid/ready pipe. Supports 64-bit and RV64 word (sign-extended 32-bit) ops.
module pipe_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic             in_sub,
  input  logic             in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_sign,
  output logic             out_carry,
  output logic             out_zero
);

  localparam int SW = WIDTH / STAGES;

  // Stage k logic reads *_in[k] and its result is captured in *_q[k].
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] r_in  [STAGES];
  logic [WIDTH-1:0] r_nxt [STAGES];
  logic             c_in  [STAGES];
  logic             c_nxt [STAGES];
  logic             sub_in  [STAGES];
  logic             word_in [STAGES];

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic             c_q [STAGES];
  logic             sub_q  [STAGES];
  logic             word_q [STAGES];
  logic [STAGES-1:0] v_q;

  logic adv;

  assign adv       = ~v_q[STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW:0]      slice_sum;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_head
      // Operand B is inverted up front so every slice is a plain add.
      assign a_in[0]    = in_op1;
      assign b_in[0]    = in_op2 ^ {WIDTH{in_sub}};
      assign r_in[0]    = '0;
      assign c_in[0]    = in_sub;
      assign sub_in[0]  = in_sub;
      assign word_in[0] = in_word;
    end else begin : g_body
      assign a_in[k]    = a_q[k-1];
      assign b_in[k]    = b_q[k-1];
      assign r_in[k]    = r_q[k-1];
      assign c_in[k]    = c_q[k-1];
      assign sub_in[k]  = sub_q[k-1];
      assign word_in[k] = word_q[k-1];
    end

    assign slice_sum = {1'b0, a_in[k][k*SW +: SW]}
                     + {1'b0, b_in[k][k*SW +: SW]}
                     + {{SW{1'b0}}, c_in[k]};

    always_comb begin
      merged                = r_in[k];
      merged[k*SW +: SW]    = slice_sum[SW-1:0];
    end

    assign r_nxt[k] = merged;
    assign c_nxt[k] = slice_sum[SW];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q <= '0;
    end else if (adv) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]    <= a_in[k];
        b_q[k]    <= b_in[k];
        r_q[k]    <= r_nxt[k];
        c_q[k]    <= c_nxt[k];
        sub_q[k]  <= sub_in[k];
        word_q[k] <= word_in[k];
      end
    end
  end

  // Flags come straight off the last stage registers, so they hold during a stall.
  logic [WIDTH-1:0] fa, fb, fr;
  logic             fcout, fsub, fword;
  logic             cin_msb, cin_31, cout_31;

  assign fa    = a_q[STAGES-1];
  assign fb    = b_q[STAGES-1];
  assign fr    = r_q[STAGES-1];
  assign fcout = c_q[STAGES-1];
  assign fsub  = sub_q[STAGES-1];
  assign fword = word_q[STAGES-1];

  // Carries around a bit are recovered from the sum bit and the (inverted) operands.
  assign cin_msb = fr[WIDTH-1] ^ fa[WIDTH-1] ^ fb[WIDTH-1];
  assign cin_31  = fr[31] ^ fa[31] ^ fb[31];
  assign cout_31 = (fa[31] & fb[31]) | (fa[31] & cin_31) | (fb[31] & cin_31);

  always_comb begin
    if (fword) begin
      out_result   = WIDTH'($signed(fr[31:0]));
      out_overflow = cin_31 ^ cout_31;
      out_sign     = fr[31];
      out_carry    = cout_31 ^ fsub;
      out_zero     = ~|fr[31:0];
    end else begin
      out_result   = fr;
      out_overflow = cin_msb ^ fcout;
      out_sign     = fr[WIDTH-1];
      out_carry    = fcout ^ fsub;
      out_zero     = ~|fr;
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: a 64x2 unit for handshake/flag scenarios and
// three more geometries checked against a behavioural reference model.
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_sub, in_word;
  logic [63:0] in_op1, in_op2;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic        out_overflow, out_sign, out_carry, out_zero;

  int checks   = 0;
  int failures = 0;
  int out_cnt  = 0;

  logic [131:0] sb_q[$];
  bit           bp_en   = 0;
  bit           hold_lo = 0;

  logic         sw_valid, sw_sub, sw_word;
  logic [127:0] sw_op1, sw_op2;
  int           sw_cnt[3];

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(64), .STAGES(2)) dut (
    .clock(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_sub(in_sub), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_sign(out_sign),
    .out_carry(out_carry), .out_zero(out_zero)
  );

  function automatic logic [131:0] pk(logic [127:0] r, logic o, logic s, logic c, logic z);
    return {o, s, c, z, r};
  endfunction

  // Reference: plain wide arithmetic, unsigned compare for borrow, sign rules for overflow.
  function automatic logic [131:0] model(int w, logic [127:0] a, logic [127:0] b, logic sub, logic word);
    int aw;
    logic [128:0] mask, wmask, am, bm, s, rs;
    logic o, sg, c, z, sa, sb;
    aw    = word ? 32 : w;
    mask  = (129'(1) << aw) - 129'(1);
    wmask = (129'(1) << w) - 129'(1);
    am    = {1'b0, a} & mask;
    bm    = {1'b0, b} & mask;
    s     = sub ? am - bm : am + bm;
    rs    = s & mask;
    c     = sub ? (am < bm) : s[aw];
    sa    = am[aw-1];
    sb    = bm[aw-1];
    sg    = rs[aw-1];
    o     = sub ? (sa != sb && sg != sa) : (sa == sb && sg != sa);
    z     = (rs == '0);
    if (sg) rs = rs | ~mask;
    rs = rs & wmask;
    return {o, sg, c, z, rs[127:0]};
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = hold_lo ? 1'b0 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Main scoreboard monitor: in_ready rule, stall stability, in-order results.
  logic [131:0] held, got, exp_v;
  bit           prev_stall = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      got = {out_overflow, out_sign, out_carry, out_zero, 64'h0, out_result};
      checks++;
      if (in_ready !== ~(out_valid & ~out_ready)) begin
        failures++;
        $display("FAIL in_ready_rule got=%b required=%b", in_ready, ~(out_valid & ~out_ready));
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || got !== held) begin
          failures++;
          $display("FAIL stall_stable got v=%b %h required v=1 %h", out_valid, got, held);
        end
      end
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          prev_stall = 0;
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output got=%h required=none", got);
          end else begin
            exp_v = sb_q.pop_front();
            out_cnt++;
            if (got !== exp_v) begin
              failures++;
              $display("FAIL sb_main got={ovf,sign,carry,zero,res}=%h required=%h", got, exp_v);
            end
          end
        end else begin
          prev_stall = 1;
          held       = got;
        end
      end else begin
        prev_stall = 0;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int W = (g == 0) ? 32 : (g == 1) ? 64 : 128;
    localparam int S = (g == 0) ? 1  : (g == 1) ? 4  : 8;
    logic         rdy, ov, o_ovf, o_sign, o_carry, o_zero;
    logic [W-1:0] res;
    logic [131:0] q[$];
    logic [131:0] e, gv;

    pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clock(clk), .reset(reset),
      .in_valid(sw_valid), .in_ready(rdy),
      .in_op1(sw_op1[W-1:0]), .in_op2(sw_op2[W-1:0]), .in_sub(sw_sub), .in_word(sw_word),
      .out_valid(ov), .out_ready(1'b1),
      .out_result(res), .out_overflow(o_ovf), .out_sign(o_sign),
      .out_carry(o_carry), .out_zero(o_zero)
    );

    always @(posedge clk)
      if (!reset && sw_valid) q.push_back(model(W, sw_op1, sw_op2, sw_sub, sw_word));

    always @(negedge clk) begin
      if (!reset && ov === 1'b1) begin
        gv = {o_ovf, o_sign, o_carry, o_zero, 128'(res)};
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sweep_unexpected w=%0d got=%h", W, gv);
        end else begin
          e = q.pop_front();
          sw_cnt[g]++;
          if (gv !== e) begin
            failures++;
            $display("FAIL sweep w=%0d s=%0d got=%h required=%h", W, S, gv, e);
          end
        end
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub,
                      input logic word, input logic [131:0] e);
    bit ok = 0;
    in_op1 = a; in_op2 = b; in_sub = sub; in_word = word; in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1;
        sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout got=not_accepted required=accepted");
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got=%0d pending required=0", name, sb_q.size());
    end
  endtask

  task automatic test_reset_latency();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_during got=%b required=0", out_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_after got=%b required=0", out_valid);
    end
    @(posedge clk); #1;
    send(64'h1, 64'h1, 1'b0, 1'b0, pk(128'h2, 0, 0, 0, 0));
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early got=%b required=0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency_arrive got=%b required=1", out_valid);
    end
    drain("latency");
  endtask

  task automatic test_carry_overflow();
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, pk(128'h8000_0000_0000_0000, 1, 1, 0, 0));
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, pk(128'h0, 0, 0, 1, 1));
    drain("carry");
  endtask

  task automatic test_subtract();
    send(64'h3, 64'h5, 1'b1, 1'b0, pk(128'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1, 0));
    send(64'h5, 64'h5, 1'b1, 1'b0, pk(128'h0, 0, 0, 0, 1));
    drain("sub");
  endtask

  task automatic test_word();
    send(64'h0000_0001_7FFF_FFFF, 64'h1, 1'b0, 1'b1, pk(128'hFFFF_FFFF_8000_0000, 1, 1, 0, 0));
    send(64'h0000_0005_0000_0000, 64'h0, 1'b0, 1'b1, pk(128'h0, 0, 0, 0, 1));
    drain("word");
  endtask

  task automatic test_back_to_back();
    int base = out_cnt;
    bp_en = 1;
    for (int i = 0; i < 8; i++) begin
      send(64'(i), 64'(100 * i), 1'b0, 1'b0, model(64, 128'(i), 128'(100 * i), 1'b0, 1'b0));
    end
    drain("stream");
    bp_en = 0;
    checks++;
    if (out_cnt - base != 8) begin
      failures++;
      $display("FAIL stream_count got=%0d required=8", out_cnt - base);
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    hold_lo = 1;
    @(posedge clk); #1;
    send(64'h11, 64'h22, 1'b0, 1'b0, model(64, 128'h11, 128'h22, 1'b0, 1'b0));
    send(64'h33, 64'h44, 1'b1, 1'b0, model(64, 128'h33, 128'h44, 1'b1, 1'b0));
    reset = 1'b1;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    hold_lo = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_midflight got=%0d outputs required=0", seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    logic [127:0] ta [10];
    logic [127:0] tb_ [10];
    logic [1:0]   tm [10];
    int n = 0;
    ta[0] = 128'h1;                      tb_[0] = 128'h1; tm[0] = 2'b00;
    ta[1] = 128'h7FFF_FFFF_FFFF_FFFF;    tb_[1] = 128'h1; tm[1] = 2'b00;
    ta[2] = 128'hFFFF_FFFF_FFFF_FFFF;    tb_[2] = 128'h1; tm[2] = 2'b00;
    ta[3] = 128'h3;                      tb_[3] = 128'h5; tm[3] = 2'b10;
    ta[4] = 128'h5;                      tb_[4] = 128'h5; tm[4] = 2'b10;
    ta[5] = 128'h1_7FFF_FFFF;            tb_[5] = 128'h1; tm[5] = 2'b01;
    ta[6] = 128'h5_0000_0000;            tb_[6] = 128'h0; tm[6] = 2'b01;
    ta[7] = {64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}; tb_[7] = 128'h1; tm[7] = 2'b00;
    ta[8] = '1;                          tb_[8] = 128'h1; tm[8] = 2'b00;
    ta[9] = 128'h0;                      tb_[9] = 128'h1; tm[9] = 2'b10;
    for (int g = 0; g < 3; g++) sw_cnt[g] = 0;
    for (int i = 0; i < 10; i++) begin
      sw_op1 = ta[i]; sw_op2 = tb_[i]; sw_sub = tm[i][1]; sw_word = tm[i][0]; sw_valid = 1'b1;
      n++;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 24; i++) begin
      sw_op1  = {$urandom, $urandom, $urandom, $urandom};
      sw_op2  = {$urandom, $urandom, $urandom, $urandom};
      sw_sub  = 1'($urandom_range(0, 1));
      sw_word = 1'($urandom_range(0, 1));
      sw_valid = 1'b1;
      n++;
      @(posedge clk); #1;
    end
    sw_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (sw_cnt[g] != n) begin
        failures++;
        $display("FAIL sweep_count cfg=%0d got=%0d required=%0d", g, sw_cnt[g], n);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op1 = '0; in_op2 = '0; in_sub = 1'b0; in_word = 1'b0;
    sw_valid = 1'b0; sw_op1 = '0; sw_op2 = '0; sw_sub = 1'b0; sw_word = 1'b0;
    @(posedge clk); #1;
    test_reset_latency();
    test_carry_overflow();
    test_subtract();
    test_word();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined integer add/subtract unit for the execute stage. It replaces the single-cycle 64-bit adder on timing-critical paths. The carry chain is split into STAGES registered slices, and operands move through the pipe on a valid/ready handshake. It supports add, subtract, and RV64 word (32-bit, sign-extended) modes, and reports overflow, sign, carry/borrow and zero flags.

## Interface
- WIDTH, 64: operand/result width; must be divisible by STAGES and ≥ 32.
- STAGES, 2: pipeline depth in cycles, which is also the number of carry-chain slices (legal values 1..8).
- clock  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- in_op1  in  WIDTH  operand A.
- in_op2  in  WIDTH  operand B.
- in_sub  in  1  1 = A − B, 0 = A + B.
- in_word  in  1  1 = 32-bit word op; result is sign-extended from bit 31.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  sum/difference.
- out_overflow  out  1  signed overflow.
- out_sign  out  1  MSB of the result (bit 31 in word mode).
- out_carry  out  1  add: carry out; sub: borrow (= cout ^ in_sub).
- out_zero  out  1  result == 0 over the active width.

## Operation
- Core arithmetic: A + (B ^ {WIDTH{sub}}) + sub.
  - Slice k (width WIDTH/STAGES) is added in pipe stage k, using the registered carry from slice k−1.
  - Slice 0 uses sub as its carry-in.
- Operand skew: the unprocessed upper operand slices, sub and word ride alongside each stage.
- Result alignment: finished lower result slices are delayed so the full result emerges aligned.
- Flags (full mode):
  - overflow = c_in(MSB) ^ c_out(MSB).
  - carry = c_out(MSB) ^ sub.
  - sign = result[WIDTH−1].
  - zero = ~|result.
- Flags (word mode):
  - Same formulas, but evaluated at bit 31 using the carries into and out of bit 31.
  - result[WIDTH−1:32] = {result[31]}.
  - zero evaluates bits 31:0 only.
  - The upper operand bits still propagate but are ignored.
- Per-stage valid bits: v[0..STAGES−1]; out_valid = v[STAGES−1].
- Global advance: adv = ~out_valid | out_ready.
  - When adv = 1, all stages shift by one and v[0] ← in_valid.
  - When adv = 0, all stage registers and valid bits hold.
- in_ready = adv, a combinational function of out_valid and out_ready only. It never depends on in_valid.
- Bubbles (v = 0) shift like data. There is no collapse: the design uses a simple stall-all pipe.
- Data registers need no reset. Only the valid bits are reset.

## Timing
- Reset:
  - v[*] = 0, so out_valid = 0 the cycle after reset is sampled.
  - While reset is high, in_ready = 1 but beats are discarded.
  - Reset mid-operation drops all in-flight beats with no output.
  - out_result and the flags are don't-care while out_valid = 0. Zeroing them is not required.
- Latency:
  - A beat accepted at edge N (in_valid & in_ready) appears with out_valid = 1 after edge N+STAGES−1.
  - Minimum input-to-output latency is therefore STAGES cycles.
  - STAGES = 1 degenerates to a single registered adder.
- Throughput: one beat per cycle while out_ready is held at 1.
- Backpressure:
  - With out_valid = 1 and out_ready = 0, out_result and all flags stay stable until the handshake completes.
  - in_ready = 0 in that cycle.
- Simultaneous events:
  - An output handshake and an input handshake in the same cycle are both legal; the pipe shifts.
  - With the pipe full, an output handshake on out_valid & out_ready accepts a new input in the same cycle. No bubble is inserted.
- Per-cycle mode: in_sub and in_word are sampled per beat, so modes may change every cycle.

## Test plan
- **Reset and latency.** WIDTH = 64, STAGES = 2. Reset, then a single beat 0x1 + 0x1 with out_ready = 1.
  - Required: out_valid rises exactly 2 cycles after acceptance, with result 0x2 and all flags 0.
  - Required: out_valid = 0 during and immediately after reset.
- **Carry across slices and overflow.** 0x7FFF_FFFF_FFFF_FFFF + 0x1.
  - Required: result 0x8000_0000_0000_0000, overflow = 1, sign = 1, carry = 0.
  - Then 0xFFFF_FFFF_FFFF_FFFF + 0x1: result 0, carry = 1, zero = 1, overflow = 0.
- **Subtract/borrow.** 0x3 − 0x5.
  - Required: result 0xFFFF_FFFF_FFFF_FFFE, carry (borrow) = 1, sign = 1.
  - 0x5 − 0x5: result 0, zero = 1, carry = 0.
- **Word mode.** in_word = 1, 0x0000_0001_7FFF_FFFF + 0x1.
  - Required: result 0xFFFF_FFFF_8000_0000, overflow = 1, sign = 1.
  - 0x0000_0005_0000_0000 + 0: zero = 1.
- **Backpressure streaming.** Push 8 back-to-back beats (i + 100·i) while toggling out_ready pseudo-randomly.
  - Required: outputs arrive in order with correct values, no loss or duplication, and outputs are stable during each stall.
  - Required: in_ready = 0 exactly when out_valid & ~out_ready.
- **Reset mid-flight and parameter sweep.**
  - Assert reset with 2 beats in flight. Required: no outputs emerge afterward.
  - Repeat the arithmetic cases for (WIDTH, STAGES) = (32, 1), (64, 4) and (128, 8) against a behavioural reference model.
